// File: rtl/memory_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_arbiter
// Description : Round-robin arbiter sharing one edge-strobed word memory port
//               between an instruction-fetch port and a load/store port.
//               Each request becomes a setup / strobe / capture sequence.
//               Misaligned or out-of-range requests get an error response
//               and never reach the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_arbiter #(
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_request,
    input  logic [31:0] instruction_address,
    output logic        instruction_acknowledge,
    output logic [31:0] instruction_read_data,
    output logic        instruction_error,
    input  logic        data_request,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic        data_acknowledge,
    output logic [31:0] data_read_data,
    output logic        data_error,
    output logic [31:0] memory_address,
    output logic [31:0] memory_write_data,
    output logic        memory_write_enable,
    output logic        memory_read_enable,
    input  logic [31:0] memory_read_data,
    output logic        busy
);

    localparam int c_PAD_WIDTH = 32 - ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        CAPTURE = 3'd3,
        RESPOND = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_last_grant_data;  // 1: data port won the most recent grant
    logic        r_grant_data;       // 1: current transaction belongs to data port
    logic        r_is_write;         // current transaction is a store

    logic        w_inst_pending;
    logic        w_data_pending;
    logic        w_grant;
    logic        w_pick_data;
    logic [31:0] w_sel_address;
    logic        w_sel_write;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [31:0] w_word_index;

    // A request whose acknowledge is being shown this cycle is masked, so a
    // requester that drops on seeing acknowledge is never issued twice.
    always_comb begin
        w_inst_pending = instruction_request & ~instruction_acknowledge;
        w_data_pending = data_request & ~data_acknowledge;
        w_grant        = w_inst_pending | w_data_pending;
        // On a tie, the port that did not win last time takes the grant.
        w_pick_data    = w_data_pending & (~w_inst_pending | ~r_last_grant_data);
        w_sel_address  = w_pick_data ? data_address : instruction_address;
        w_sel_write    = w_pick_data & data_write;
        w_misaligned   = |w_sel_address[1:0];
        w_out_of_range = |(w_sel_address >> (ADDRESS_WIDTH + 2));
        w_word_index   = {{c_PAD_WIDTH{1'b0}}, w_sel_address[ADDRESS_WIDTH+1:2]};
    end

    // Arbitration and memory sequencing FSM; every output is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state                 <= IDLE;
            r_last_grant_data       <= 1'b1;
            r_grant_data            <= 1'b0;
            r_is_write              <= 1'b0;
            instruction_acknowledge <= 1'b0;
            instruction_read_data   <= 32'd0;
            instruction_error       <= 1'b0;
            data_acknowledge        <= 1'b0;
            data_read_data          <= 32'd0;
            data_error              <= 1'b0;
            memory_address          <= 32'd0;
            memory_write_data       <= 32'd0;
            memory_write_enable     <= 1'b0;
            memory_read_enable      <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            // Acknowledges and strobes are single-cycle pulses.
            instruction_acknowledge <= 1'b0;
            data_acknowledge        <= 1'b0;
            memory_write_enable     <= 1'b0;
            memory_read_enable      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_grant_data      <= w_pick_data;
                        r_last_grant_data <= w_pick_data;
                        busy              <= 1'b1;
                        if (w_misaligned || w_out_of_range) begin
                            r_state <= RESPOND;
                        end else begin
                            memory_address    <= w_word_index;
                            memory_write_data <= w_sel_write ? data_write_data : 32'd0;
                            r_is_write        <= w_sel_write;
                            r_state           <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    // Address/data have been stable for a full cycle; raise
                    // exactly one strobe for the next cycle.
                    memory_write_enable <= r_is_write;
                    memory_read_enable  <= ~r_is_write;
                    r_state             <= STROBE;
                end

                STROBE: begin
                    r_state <= CAPTURE;
                end

                CAPTURE: begin
                    if (r_grant_data) begin
                        if (!r_is_write) begin
                            data_read_data <= memory_read_data;
                        end
                        data_acknowledge <= 1'b1;
                        data_error       <= 1'b0;
                    end else begin
                        instruction_read_data   <= memory_read_data;
                        instruction_acknowledge <= 1'b1;
                        instruction_error       <= 1'b0;
                    end
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                RESPOND: begin
                    if (r_grant_data) begin
                        data_acknowledge <= 1'b1;
                        data_error       <= 1'b1;
                    end else begin
                        instruction_acknowledge <= 1'b1;
                        instruction_error       <= 1'b1;
                    end
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_arbiter
// Description : Self-checking bench for memory_access_arbiter with a 256-word
//               edge-triggered memory model and an acknowledge scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_arbiter;

    logic        clk;
    logic        reset;
    logic        instruction_request;
    logic [31:0] instruction_address;
    logic        instruction_acknowledge;
    logic [31:0] instruction_read_data;
    logic        instruction_error;
    logic        data_request;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic        data_acknowledge;
    logic [31:0] data_read_data;
    logic        data_error;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic        memory_write_enable;
    logic        memory_read_enable;
    logic [31:0] memory_read_data;
    logic        busy;

    memory_access_arbiter #(.ADDRESS_WIDTH(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .instruction_request     (instruction_request),
        .instruction_address     (instruction_address),
        .instruction_acknowledge (instruction_acknowledge),
        .instruction_read_data   (instruction_read_data),
        .instruction_error       (instruction_error),
        .data_request            (data_request),
        .data_write              (data_write),
        .data_address            (data_address),
        .data_write_data         (data_write_data),
        .data_acknowledge        (data_acknowledge),
        .data_read_data          (data_read_data),
        .data_error              (data_error),
        .memory_address          (memory_address),
        .memory_write_data       (memory_write_data),
        .memory_write_enable     (memory_write_enable),
        .memory_read_enable      (memory_read_enable),
        .memory_read_data        (memory_read_data),
        .busy                    (busy)
    );

    typedef struct {
        bit          port;   // 0 = instruction, 1 = data
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          re_count = 0;
    int          we_count = 0;
    logic [31:0] mem [0:255];

    function automatic logic [31:0] mem_init(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory model acting on strobe rising edges.
    always @(posedge memory_write_enable) mem[memory_address[7:0]] = memory_write_data;
    always @(posedge memory_read_enable) memory_read_data = mem[memory_address[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input bit port);
        exp_t e;
        check("ack_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("grant_port", {31'd0, port}, {31'd0, e.port});
            if (port) begin
                check("data_read_data", data_read_data, e.data);
                check("data_error", {31'd0, data_error}, {31'd0, e.err});
            end else begin
                check("instruction_read_data", instruction_read_data, e.data);
                check("instruction_error", {31'd0, instruction_error}, {31'd0, e.err});
            end
        end
    endtask

    // Output monitor: strobe counts, strobe exclusivity, scoreboard pops.
    always @(negedge clk) begin
        if (reset) begin
            if (memory_read_enable) re_count++;
            if (memory_write_enable) we_count++;
            if (memory_read_enable || memory_write_enable)
                check("enable_overlap", {31'd0, memory_read_enable & memory_write_enable}, 32'd0);
            if (instruction_acknowledge) sb_pop(1'b0);
            if (data_acknowledge) sb_pop(1'b1);
        end
    end

    task automatic push(input bit port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Issue one request, wait (bounded) for its acknowledge, return latency.
    task automatic run_req(input bit port, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, output int lat);
        int start;
        bit seen;
        @(negedge clk);
        start = cycle;
        if (!port) begin
            instruction_address = addr;
            instruction_request = 1'b1;
        end else begin
            data_address    = addr;
            data_write      = wr;
            data_write_data = wd;
            data_request    = 1'b1;
        end
        seen = 1'b0;
        lat  = 999;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((!port && instruction_acknowledge) || (port && data_acknowledge)) begin
                seen = 1'b1;
                lat  = cycle - start;
            end
        end
        instruction_request = 1'b0;
        data_request        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          re0;
        int          we0;
        int          n;
        logic [31:0] exp_ird;
        logic [31:0] exp_drd;

        for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
        memory_read_data    = 32'd0;
        reset               = 1'b0;
        instruction_request = 1'b0;
        instruction_address = 32'd0;
        data_request        = 1'b0;
        data_write          = 1'b0;
        data_address        = 32'd0;
        data_write_data     = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_instruction_acknowledge", {31'd0, instruction_acknowledge}, 32'd0);
        check("rst_instruction_read_data", instruction_read_data, 32'd0);
        check("rst_instruction_error", {31'd0, instruction_error}, 32'd0);
        check("rst_data_acknowledge", {31'd0, data_acknowledge}, 32'd0);
        check("rst_data_read_data", data_read_data, 32'd0);
        check("rst_data_error", {31'd0, data_error}, 32'd0);
        check("rst_memory_address", memory_address, 32'd0);
        check("rst_memory_write_data", memory_write_data, 32'd0);
        check("rst_memory_write_enable", {31'd0, memory_write_enable}, 32'd0);
        check("rst_memory_read_enable", {31'd0, memory_read_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        exp_ird = 32'd0;
        exp_drd = 32'd0;

        // Fetch only at 0x10
        re0 = re_count; we0 = we_count;
        exp_ird = mem_init(4);
        push(1'b0, exp_ird, 1'b0);
        run_req(1'b0, 32'h10, 1'b0, 32'd0, lat);
        check("fetch_latency", lat, 32'd4);
        check("fetch_memory_address", memory_address, 32'h4);
        check("fetch_read_strobes", re_count - re0, 32'd1);
        check("fetch_write_strobes", we_count - we0, 32'd0);

        // Store 0xDEADBEEF to 0x20
        re0 = re_count; we0 = we_count;
        push(1'b1, exp_drd, 1'b0);
        run_req(1'b1, 32'h20, 1'b1, 32'hDEADBEEF, lat);
        check("store_latency", lat, 32'd4);
        check("store_write_strobes", we_count - we0, 32'd1);
        check("store_read_strobes", re_count - re0, 32'd0);
        check("store_memory_word", mem[8], 32'hDEADBEEF);

        // Load back from 0x20
        re0 = re_count; we0 = we_count;
        exp_drd = 32'hDEADBEEF;
        push(1'b1, exp_drd, 1'b0);
        run_req(1'b1, 32'h20, 1'b0, 32'd0, lat);
        check("load_latency", lat, 32'd4);
        check("load_read_strobes", re_count - re0, 32'd1);
        check("load_write_strobes", we_count - we0, 32'd0);

        // Simultaneous requests held for four transactions: I, D, I, D
        re0 = re_count; we0 = we_count;
        exp_ird = mem_init(16);
        exp_drd = mem_init(17);
        push(1'b0, exp_ird, 1'b0);
        push(1'b1, exp_drd, 1'b0);
        push(1'b0, exp_ird, 1'b0);
        push(1'b1, exp_drd, 1'b0);
        @(negedge clk);
        instruction_address = 32'h40;
        data_address        = 32'h44;
        data_write          = 1'b0;
        instruction_request = 1'b1;
        data_request        = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (instruction_acknowledge) n++;
            if (data_acknowledge) n++;
        end
        instruction_request = 1'b0;
        data_request        = 1'b0;
        check("arb_ack_count", n, 32'd4);
        repeat (8) @(negedge clk);
        check("arb_read_strobes", re_count - re0, 32'd4);
        check("arb_write_strobes", we_count - we0, 32'd0);
        check("arb_scoreboard_empty", sb.size(), 32'd0);
        check("arb_busy_after", {31'd0, busy}, 32'd0);

        // Misaligned data load at 0x22
        re0 = re_count; we0 = we_count;
        push(1'b1, exp_drd, 1'b1);
        run_req(1'b1, 32'h22, 1'b0, 32'd0, lat);
        check("misaligned_latency", lat, 32'd2);
        check("misaligned_read_strobes", re_count - re0, 32'd0);
        check("misaligned_write_strobes", we_count - we0, 32'd0);

        // Out-of-range fetch at 0x400
        re0 = re_count; we0 = we_count;
        push(1'b0, exp_ird, 1'b1);
        run_req(1'b0, 32'h400, 1'b0, 32'd0, lat);
        check("range_latency", lat, 32'd2);
        check("range_read_strobes", re_count - re0, 32'd0);
        check("range_write_strobes", we_count - we0, 32'd0);

        // Highest valid fetch at 0x3FC
        re0 = re_count;
        exp_ird = mem_init(255);
        push(1'b0, exp_ird, 1'b0);
        run_req(1'b0, 32'h3FC, 1'b0, 32'd0, lat);
        check("top_latency", lat, 32'd4);
        check("top_memory_address", memory_address, 32'd255);
        check("top_read_strobes", re_count - re0, 32'd1);

        // Reset asserted during the strobe of a load
        @(negedge clk);
        data_address = 32'h44;
        data_write   = 1'b0;
        data_request = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (memory_read_enable) n = 1;
        end
        check("midreset_strobe_seen", n, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset_read_enable", {31'd0, memory_read_enable}, 32'd0);
        check("midreset_write_enable", {31'd0, memory_write_enable}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_data_ack", {31'd0, data_acknowledge}, 32'd0);
        data_request = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_data_ack_held", {31'd0, data_acknowledge}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_no_ack_after", {31'd0, data_acknowledge}, 32'd0);

        // Reissued load completes normally
        re0 = re_count;
        exp_drd = mem_init(17);
        push(1'b1, exp_drd, 1'b0);
        run_req(1'b1, 32'h44, 1'b0, 32'd0, lat);
        check("reissue_latency", lat, 32'd4);
        check("reissue_read_strobes", re_count - re0, 32'd1);

        repeat (4) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
- Shares one word-wide, edge-strobed memory port between two requesters: the instruction-fetch port (read-only) and the load/store port (read/write).
- Converts each request/acknowledge transaction into a registered setup, enable-pulse and capture sequence for the memory.
- Round-robin arbitration with byte-to-word address translation.
- Sits between the core's fetch/memory stages and the memory interface module.

Parameters:
ADDRESS_WIDTH, 8, memory word-index width; valid byte addresses are 0 .. 4*2^ADDRESS_WIDTH-4.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instruction_request  input  1  fetch request; held high with stable address until acknowledge
instruction_address  input  32  fetch byte address
instruction_acknowledge  output  1  one-cycle completion pulse
instruction_read_data  output  32  fetched word; valid with acknowledge, held afterwards
instruction_error  output  1  misaligned or out-of-range; valid with acknowledge
data_request  input  1  load/store request; held with stable inputs until acknowledge
data_write  input  1  1 = store, 0 = load
data_address  input  32  load/store byte address
data_write_data  input  32  store word
data_acknowledge  output  1  one-cycle completion pulse
data_read_data  output  32  loaded word; updated only on load acknowledge
data_error  output  1  misaligned or out-of-range; valid with acknowledge
memory_address  output  32  word index, zero-extended from byte_address[ADDRESS_WIDTH+1:2]
memory_write_data  output  32  store word to memory
memory_write_enable  output  1  registered write strobe
memory_read_enable  output  1  registered read strobe
memory_read_data  input  32  memory read word
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE, last_grant = data (instruction wins first tie), all outputs 0.
- All outputs are registered. memory_*_enable must be glitch-free because the memory acts on enable rising edges.
- States: IDLE, SETUP, STROBE, CAPTURE, RESPOND.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - Update last_grant on every grant.
- Address check at grant:
  - Error if address[1:0] != 0.
  - Error if address[31:ADDRESS_WIDTH+2] != 0.
  - Error grant: go to RESPOND; no memory enable is ever raised.
  - Valid grant: latch the word index, write data and write flag; go to SETUP.
- SETUP: memory_address and memory_write_data are driven; both enables stay 0. Next state: STROBE.
- STROBE: exactly one enable is high for one cycle (write enable for a store, read enable for a load or fetch). Next state: CAPTURE.
- CAPTURE:
  - Enables return to 0.
  - For a read, register memory_read_data into the granted port's read_data.
  - Pulse the granted acknowledge with error = 0.
  - Next state: IDLE.
- RESPOND:
  - Pulse the granted acknowledge with error = 1.
  - Read data outputs hold their previous value.
  - Next state: IDLE.
- Latency and throughput:
  - Valid request sampled at edge n: acknowledge is high during the cycle after edge n+3.
  - Error request sampled at edge n: acknowledge is high during the cycle after edge n+1.
  - Maximum rate is one valid access per 4 cycles.
- Requester rule: may drop or change its request after seeing acknowledge. Because CAPTURE and RESPOND always return to IDLE, no duplicate issue occurs.
- Stores never modify data_read_data. The instruction port has no write path.
- An un-granted request is held pending; it is never dropped.
- Request inputs change only after acknowledge. Behaviour under mid-transaction changes is undefined.
- Reset asserted mid-transaction (any state):
  - Enables drop immediately and no acknowledge is issued.
  - A store whose strobe edge has already occurred stays written.
  - Requesters must reissue after reset.

Test Plan:
- Fetch only: instruction_address = 0x10 -> memory_address = 0x4, read strobe 1 cycle, ack 4 cycles after sampling, instruction_read_data = mem[4], error = 0.
- Store then load: store 0xDEADBEEF to 0x20, then load 0x20 -> write strobe only on the store, data_read_data = 0xDEADBEEF, unchanged after the store ack.
- Simultaneous requests held high for 4 transactions -> grant order instruction, data, instruction, data; each ack exactly once; no overlapping enables.
- Misaligned data load at 0x22 -> data_error = 1, ack 2 cycles after sampling, enables never asserted, data_read_data unchanged.
- Out-of-range fetch at 0x400 with ADDRESS_WIDTH = 8 -> instruction_error = 1, no strobe. Address 0x3FC succeeds, reading mem[255].
- Reset pulsed low during STROBE of a load -> enables 0 asynchronously, state IDLE, no ack. After release, a reissued request completes normally.
